// File: rtl/lcd_key_pkg.sv
// lcd_key_pkg
// Shared types and constants for the IR-key-to-LCD scheduler:
//   - state_t    : scheduler FSM states
//   - key_map_t  : result of mapping an IR code {valid, is_clear, ascii}
//   - LCD command constants (clear display, set DDRAM address, row 1 offset)
//   - map_key()  : IR code -> key_map_t
package lcd_key_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    CLR  = 2'd3
  } state_t;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_DDRAM = 8'h80;
  localparam logic [7:0] LCD_ROW1_OFS  = 8'h40;

  typedef struct packed {
    logic       valid;
    logic       is_clear;
    logic [7:0] ascii;
  } key_map_t;

  // The clear code is checked first so it wins should it ever be
  // configured onto a code that also has a character mapping.
  function automatic key_map_t map_key(input logic [7:0] code,
                                       input logic [7:0] clear_code);
    key_map_t m;
    m = '0;
    if (code == clear_code) begin
      m.valid    = 1'b1;
      m.is_clear = 1'b1;
    end else if (code <= 8'h09) begin
      m.valid = 1'b1;
      m.ascii = 8'h30 | code;
    end else begin
      case (code)
        8'h0F: begin m.valid = 1'b1; m.ascii = 8'h41; end
        8'h13: begin m.valid = 1'b1; m.ascii = 8'h42; end
        8'h10: begin m.valid = 1'b1; m.ascii = 8'h43; end
        default: m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/lcd_key_scheduler_fifo.sv
// lcd_key_fifo
// Small synchronous FIFO holding mapped key entries.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write request and data (accepted when not full, or when
//              full with a simultaneous pop)
//   pop/dout : read request; dout always shows the head entry
//   full, empty, level : occupancy status (level is registered)
module lcd_key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;

  logic w_do_pop;
  logic w_do_push;

  assign empty     = (r_level == '0);
  assign full      = (r_level == (AW+1)'(DEPTH));
  assign w_do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_do_push = push && (!full || w_do_pop);
  // Head is read straight from the array so the FSM can act on it the
  // same cycle it becomes visible.
  assign dout      = r_mem[r_rd_ptr];
  assign level     = r_level;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
      else if (!w_do_push && w_do_pop) r_level <= r_level - 1'b1;
    end
  end

endmodule

// File: rtl/lcd_key_scheduler.sv
// lcd_key_scheduler
// Queues decoded IR key events and writes them to a character LCD as a
// set-DDRAM-address command followed by a data byte, tracking the cursor.
//   clk, rst          : clock, asynchronous active-high reset
//   key_valid/key_code: 1-cycle key event from the IR front end
//   lcd_on            : LCD ready; new transactions start only when high
//   lcd_req/rs/byte   : request to the LCD byte writer, held until lcd_done
//   lcd_done          : 1-cycle completion pulse from the byte writer
//   cursor_col/row    : current cursor position
//   fifo_level        : number of buffered keys
//   busy              : transaction in progress or keys pending
//   drop_pulse        : key discarded (unmapped code or FIFO full)
module lcd_key_scheduler
  import lcd_key_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         COLS       = 16,
  parameter int         ROWS       = 2,
  parameter logic [7:0] CLEAR_CODE = 8'h12
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      key_valid,
  input  logic [7:0]                                key_code,
  input  logic                                      lcd_on,
  output logic                                      lcd_req,
  output logic                                      lcd_rs,
  output logic [7:0]                                lcd_byte,
  input  logic                                      lcd_done,
  output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] cursor_col,
  output logic                                      cursor_row,
  output logic [$clog2(FIFO_DEPTH):0]               fifo_level,
  output logic                                      busy,
  output logic                                      drop_pulse
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  key_map_t   w_map;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic [8:0] w_head;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_gap;
  logic       w_gap_next;
  logic [7:0] r_ascii;
  logic [CW-1:0] r_col;
  logic       r_row;
  logic       r_drop;
  logic       w_advance;
  logic       w_home;

  assign w_map  = map_key(key_code, CLEAR_CODE);
  assign w_push = key_valid && w_map.valid;
  assign w_pop  = (r_state == IDLE) && lcd_on && !w_empty;

  lcd_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   ({w_map.is_clear, w_map.ascii}),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  // Next state and LCD outputs. r_gap marks the single idle cycle between
  // the address byte and the data byte, during which lcd_req is low and any
  // lcd_done is ignored.
  always_comb begin
    w_state_next = r_state;
    w_gap_next   = 1'b0;
    lcd_req      = 1'b0;
    lcd_rs       = 1'b0;
    lcd_byte     = 8'h00;
    w_advance    = 1'b0;
    w_home       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pop) w_state_next = w_head[8] ? CLR : ADDR;
      end
      ADDR: begin
        lcd_req  = 1'b1;
        lcd_byte = LCD_CMD_DDRAM | (r_row ? LCD_ROW1_OFS : 8'h00) | 8'(r_col);
        if (lcd_done) begin
          w_state_next = DATA;
          w_gap_next   = 1'b1;
        end
      end
      DATA: begin
        lcd_req  = !r_gap;
        lcd_rs   = 1'b1;
        lcd_byte = r_ascii;
        if (lcd_done && !r_gap) begin
          w_advance    = 1'b1;
          w_state_next = IDLE;
        end
      end
      CLR: begin
        lcd_req  = 1'b1;
        lcd_byte = LCD_CMD_CLEAR;
        if (lcd_done) begin
          w_home       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gap   <= 1'b0;
      r_ascii <= 8'h00;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_gap   <= w_gap_next;
      if (w_pop) r_ascii <= w_head[7:0];
      // Unmapped code, or FIFO full with no pop to make room.
      r_drop  <= key_valid && (!w_map.valid || (w_full && !w_pop));
    end
  end

  // Cursor: column first, then row, wrapping to home at the last cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= 1'b0;
    end else if (w_home) begin
      r_col <= '0;
      r_row <= 1'b0;
    end else if (w_advance) begin
      if (r_col == CW'(COLS - 1)) begin
        r_col <= '0;
        if ((ROWS == 1) || r_row) r_row <= 1'b0;
        else                      r_row <= 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  assign cursor_col = r_col;
  assign cursor_row = r_row;
  assign busy       = (r_state != IDLE) || !w_empty;
  assign drop_pulse = r_drop;

endmodule

// File: doc/lcd_key_scheduler.md
Name: lcd_key_scheduler

Overview:
Sequences decoded IR key events onto the character LCD.
- Accepts 1-cycle key events (code + valid pulse) from the IR receiver path and buffers them in a small FIFO.
- Maps each key to ASCII and issues a set-DDRAM-address command followed by a data write to the LCD byte writer, using a req/done handshake.
- Tracks the cursor with row/column wrap and handles a clear-display key.
- Sits between the IR receiver front end and the LCD byte writer; replaces ad-hoc pulse-delay chains.

Parameters:
FIFO_DEPTH, 4, key FIFO entries (power of two, >=2)
COLS, 16, characters per LCD row
ROWS, 2, LCD rows (1 or 2)
CLEAR_CODE, 8'h12, IR code that clears the display

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous active-high reset
key_valid  in  1  1-cycle pulse, new IR code available
key_code  in  8  IR code, valid when key_valid=1
lcd_on  in  1  LCD powered and initialised; 0 = hold off new transactions
lcd_req  out  1  transaction request, held until lcd_done
lcd_rs  out  1  0 = command, 1 = data; stable while lcd_req=1
lcd_byte  out  8  command/data byte; stable while lcd_req=1
lcd_done  in  1  1-cycle pulse, writer finished current byte
cursor_col  out  $clog2(COLS)  current column
cursor_row  out  1  current row
fifo_level  out  $clog2(FIFO_DEPTH)+1  buffered key count
busy  out  1  FSM not in IDLE or FIFO non-empty
drop_pulse  out  1  1-cycle pulse, key discarded (FIFO full or unmapped code)

Behaviour:
- Reset values (async, rst=1): all outputs 0, FIFO empty, cursor (0,0), FSM IDLE. Reset mid-transaction drops lcd_req immediately; no completion is awaited.
- Key map:
  - 0x00-0x09 -> ASCII 0x30-0x39
  - 0x0F -> 'A' 0x41; 0x13 -> 'B' 0x42; 0x10 -> 'C' 0x43
  - CLEAR_CODE -> clear op
  - Any other code -> drop_pulse on the cycle after key_valid; not stored.
- Mapping happens at push time. Each FIFO entry is {is_clear, ascii[7:0]}.
- FIFO:
  - Push on key_valid with a mapped code.
  - If full and no pop in the same cycle: entry discarded, drop_pulse the next cycle.
  - If full with a simultaneous pop: push accepted.
  - fifo_level is updated the cycle after the event.
- FSM states:
  - IDLE: if lcd_on=1 and FIFO non-empty, pop the head; go to CLR if is_clear, else ADDR.
  - ADDR: lcd_req=1, lcd_rs=0, lcd_byte = 8'h80 | (row ? 8'h40 : 0) | col. On lcd_done go to DATA.
  - DATA: lcd_req=1, lcd_rs=1, lcd_byte = ascii. On lcd_done advance the cursor and go to IDLE.
  - CLR: lcd_req=1, lcd_rs=0, lcd_byte=8'h01. On lcd_done set cursor to (0,0) and go to IDLE.
- lcd_req drops in the cycle after lcd_done is sampled. A new request needs at least one cycle with lcd_req=0 between bytes.
- lcd_done while not requesting is ignored.
- Cursor advance:
  - col+1.
  - If col=COLS-1: col=0, row+1.
  - If row=ROWS-1 too: wrap to (0,0). There is no scroll or auto-clear.
- lcd_on:
  - Sampled only in IDLE. Falling during a transaction does not abort it; the current byte completes.
  - Keys keep queueing while lcd_on=0.
- Latency: key_valid at cycle N with FSM IDLE, FIFO empty and lcd_on=1 -> entry stored at N+1, popped, lcd_req=1 at N+2.
- No timeouts: the FSM waits indefinitely for lcd_done.

Decomposition:
- Package lcd_key_pkg holds:
  - FSM state enum {IDLE, ADDR, DATA, CLR}
  - LCD_CMD_CLEAR=8'h01, LCD_CMD_DDRAM=8'h80, LCD_ROW1_OFS=8'h40
  - the key-to-ASCII mapping function, returning {valid, is_clear, ascii}
- One sub-module, lcd_key_fifo: synchronous FIFO with width 9 and depth FIFO_DEPTH, exposing push, pop, full, empty and level.

Test Plan:
- Reset then key 0x05 with lcd_on=1 -> lcd_req at N+2 with rs=0, byte 0x80; after done, rs=1, byte 0x35; cursor (1,0).
- 17 digit keys, each completed -> 17th address byte is 0xC0; after the 32nd char the cursor returns to (0,0) and the next address byte is 0x80.
- 6 keys back-to-back with lcd_done withheld (FIFO_DEPTH=4; first popped, 4 queued) -> 6th key gives drop_pulse; fifo_level=4; releasing done produces exactly 5 characters in order.
- Key 0x0F then CLEAR_CODE then 0x13 -> bytes 0x80/'A', then 0x01 (rs=0), then 0x80/'B'; cursor (1,0) at end.
- Key 0x55 -> drop_pulse one cycle later; fifo_level stays 0; no lcd_req.
- lcd_on=0 while 2 keys arrive -> no lcd_req, fifo_level=2; raise lcd_on -> both written. Assert rst during DATA -> lcd_req=0 immediately; cursor (0,0); FIFO empty.
